// File: rtl/maj_fold_ctrl.sv
// Folded majority/threshold evaluator: a captured N-bit vector is counted CHUNK bits
// per cycle through one shared popcount slice and the count is compared against THRESH.
module maj_fold_ctrl #(
    parameter int N          = 127,
    parameter int CHUNK      = 16,
    parameter int THRESH     = (N + 1) / 2,
    parameter bit EARLY_EXIT = 1'b0,
    localparam int NCHUNK    = (N + CHUNK - 1) / CHUNK,
    localparam int CW        = $clog2(N + 1)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [N-1:0]  in_data,
    output logic          out_valid,
    input  logic          out_ready,
    output logic          out_maj,
    output logic [CW-1:0] out_count,
    output logic          busy
);

    localparam int PADW = NCHUNK * CHUNK;
    localparam int IW   = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
    localparam int SW   = $clog2(PADW + 1) + 1;

    localparam logic [IW-1:0] IDX_LAST = IW'(NCHUNK - 1);
    localparam logic [SW-1:0] N_W      = SW'(N);
    localparam logic [SW-1:0] CHUNK_W  = SW'(CHUNK);
    localparam logic [SW-1:0] THRESH_W = SW'(THRESH);
    localparam logic [CW-1:0] THRESH_C = CW'(THRESH);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t          state_q, state_d;
    logic [PADW-1:0] data_q, data_d;
    logic [IW-1:0]   idx_q, idx_d;
    logic [CW-1:0]   acc_q, acc_d;
    logic            in_ready_q, in_ready_d;
    logic            out_valid_q, out_valid_d;
    logic            out_maj_q, out_maj_d;
    logic [CW-1:0]   out_count_q, out_count_d;
    logic            busy_q, busy_d;

    logic [CHUNK-1:0] chunk;
    logic [CW-1:0]    acc_new;
    logic [SW-1:0]    reach;
    logic             last_chunk;
    logic             decided_hi;
    logic             decided_lo;
    logic             finish;
    logic             accept;
    logic             out_fire;

    function automatic logic [CW-1:0] popcount(input logic [CHUNK-1:0] v);
        logic [CW-1:0] c;
        c = '0;
        for (int i = 0; i < CHUNK; i++) begin
            c = c + CW'(v[i]);
        end
        return c;
    endfunction

    // Real (non-pad) bits still uncounted once chunk idx has been added in.
    function automatic logic [SW-1:0] remaining(input logic [IW-1:0] idx);
        logic [SW-1:0] counted;
        counted = (SW'(idx) + SW'(1)) * CHUNK_W;
        return (counted >= N_W) ? '0 : (N_W - counted);
    endfunction

    // The captured vector shifts down one chunk per cycle, so the slice is always the low bits.
    assign chunk      = data_q[CHUNK-1:0];
    assign acc_new    = acc_q + popcount(chunk);
    assign reach      = SW'(acc_new) + remaining(idx_q);
    assign last_chunk = (idx_q == IDX_LAST);
    assign decided_hi = EARLY_EXIT && (acc_new >= THRESH_C);
    assign decided_lo = EARLY_EXIT && (reach < THRESH_W);
    assign finish     = last_chunk || decided_hi || decided_lo;
    assign accept     = (state_q == IDLE) && in_valid && in_ready_q;
    assign out_fire   = (state_q == DONE) && out_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (accept) state_d = ACCUM;
            ACCUM:   if (finish) state_d = DONE;
            DONE:    if (out_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        data_d = data_q;
        idx_d  = idx_q;
        acc_d  = acc_q;
        if (accept) begin
            data_d = PADW'(in_data);
            idx_d  = '0;
            acc_d  = '0;
        end else if (state_q == ACCUM) begin
            data_d = data_q >> CHUNK;
            acc_d  = acc_new;
            idx_d  = finish ? idx_q : (idx_q + IW'(1));
        end
    end

    // Outputs are registered from the next state, so nothing reaches them from in_* combinationally.
    always_comb begin
        in_ready_d  = (state_d == IDLE);
        busy_d      = (state_d != IDLE);
        out_valid_d = (state_d == DONE);
        out_maj_d   = out_maj_q;
        out_count_d = out_count_q;
        if ((state_q == ACCUM) && finish) begin
            out_maj_d   = (acc_new >= THRESH_C);
            out_count_d = acc_new;
        end else if (out_fire) begin
            out_maj_d   = 1'b0;
            out_count_d = '0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            data_q      <= '0;
            idx_q       <= '0;
            acc_q       <= '0;
            in_ready_q  <= 1'b0;
            out_valid_q <= 1'b0;
            out_maj_q   <= 1'b0;
            out_count_q <= '0;
            busy_q      <= 1'b0;
        end else begin
            data_q      <= data_d;
            idx_q       <= idx_d;
            acc_q       <= acc_d;
            in_ready_q  <= in_ready_d;
            out_valid_q <= out_valid_d;
            out_maj_q   <= out_maj_d;
            out_count_q <= out_count_d;
            busy_q      <= busy_d;
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign out_maj   = out_maj_q;
    assign out_count = out_count_q;
    assign busy      = busy_q;

endmodule

// File: tb/tb_maj_fold_ctrl.sv
// Bench for maj_fold_ctrl: default, early-exit and small (N=7) instances checked
// against a chunk-by-chunk popcount reference model.
module tb_maj_fold_ctrl;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_n = 1'b1;

    logic         in_valid = 1'b0;
    logic [126:0] in_data  = '0;
    logic         out_ready = 1'b1;

    logic       in_ready0, out_valid0, out_maj0, busy0;
    logic [6:0] out_count0;
    logic       in_ready1, out_valid1, out_maj1, busy1;
    logic [6:0] out_count1;

    logic       in_valid_s = 1'b0;
    logic [6:0] in_data_s  = '0;
    logic       out_ready_s = 1'b1;
    logic       in_ready_s, out_valid_s, out_maj_s, busy_s;
    logic [2:0] out_count_s;

    int total  = 0;
    int passed = 0;
    int failed = 0;

    maj_fold_ctrl dut0 (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready0), .in_data(in_data),
        .out_valid(out_valid0), .out_ready(out_ready),
        .out_maj(out_maj0), .out_count(out_count0), .busy(busy0)
    );

    maj_fold_ctrl #(.EARLY_EXIT(1'b1)) dut1 (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready1), .in_data(in_data),
        .out_valid(out_valid1), .out_ready(out_ready),
        .out_maj(out_maj1), .out_count(out_count1), .busy(busy1)
    );

    maj_fold_ctrl #(.N(7), .CHUNK(3), .THRESH(4), .EARLY_EXIT(1'b1)) dut_s (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid_s), .in_ready(in_ready_s), .in_data(in_data_s),
        .out_valid(out_valid_s), .out_ready(out_ready_s),
        .out_maj(out_maj_s), .out_count(out_count_s), .busy(busy_s)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else begin
            failed++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Reference: after k chunks the first min(k*chunk, n) bits are counted; stop on the
    // last chunk, or (early) once the count reaches thr or can no longer reach it.
    function automatic void model(input logic [126:0] v, input int n, input int chunk,
                                  input int thr, input bit early,
                                  output int lat, output int cnt);
        int nch;
        int counted;
        int acc;
        nch = (n + chunk - 1) / chunk;
        lat = nch;
        cnt = 0;
        for (int k = 1; k <= nch; k++) begin
            counted = (k * chunk > n) ? n : k * chunk;
            acc = 0;
            for (int b = 0; b < counted; b++) acc += int'(v[b]);
            if (k == nch || (early && (acc >= thr || acc + (n - counted) < thr))) begin
                lat = k;
                cnt = acc;
                return;
            end
        end
    endfunction

    function automatic logic [126:0] rand_vec();
        logic [127:0] t;
        t = {$urandom(), $urandom(), $urandom(), $urandom()};
        return t[126:0];
    endfunction

    function automatic logic [126:0] weight_vec(input int w);
        logic [126:0] v;
        int c;
        int b;
        v = '0;
        c = 0;
        while (c < w) begin
            b = $urandom_range(126, 0);
            if (!v[b]) begin
                v[b] = 1'b1;
                c++;
            end
        end
        return v;
    endfunction

    function automatic logic [126:0] low_ones(input int w);
        logic [126:0] v;
        v = '0;
        for (int i = 0; i < w; i++) v[i] = 1'b1;
        return v;
    endfunction

    task automatic run_main(input logic [126:0] v, input string tag);
        int lat0, cnt0, lat1, cnt1, seen0, seen1;
        logic m0, m1;
        logic [6:0] k0, k1;
        model(v, 127, 16, 64, 1'b0, lat0, cnt0);
        model(v, 127, 16, 64, 1'b1, lat1, cnt1);
        seen0 = 0; seen1 = 0; m0 = 1'b0; m1 = 1'b0; k0 = '0; k1 = '0;
        check({tag, " in_ready0 idle"}, 32'(in_ready0), 32'd1);
        check({tag, " in_ready1 idle"}, 32'(in_ready1), 32'd1);
        in_valid = 1'b1;
        in_data  = v;
        @(posedge clk); #1;
        in_valid = 1'b0;
        for (int c = 1; c <= 10; c++) begin
            in_data  = rand_vec();
            in_valid = (c < 4) ? 1'($urandom_range(1, 0)) : 1'b0;
            @(posedge clk); #1;
            if (out_valid0 && seen0 == 0) begin seen0 = c; m0 = out_maj0; k0 = out_count0; end
            if (out_valid1 && seen1 == 0) begin seen1 = c; m1 = out_maj1; k1 = out_count1; end
            if (c == 1) begin
                check({tag, " busy0 accum"}, 32'(busy0), 32'd1);
                check({tag, " in_ready0 accum"}, 32'(in_ready0), 32'd0);
            end
            if (c == lat0 + 1) begin
                check({tag, " in_ready0 after hs"}, 32'(in_ready0), 32'd1);
                check({tag, " out_valid0 after hs"}, 32'(out_valid0), 32'd0);
            end
        end
        in_valid = 1'b0;
        check({tag, " latency0"}, 32'(seen0), 32'(lat0));
        check({tag, " maj0"}, 32'(m0), 32'(cnt0 >= 64));
        check({tag, " count0"}, 32'(k0), 32'(cnt0));
        check({tag, " latency1"}, 32'(seen1), 32'(lat1));
        check({tag, " maj1"}, 32'(m1), 32'(cnt1 >= 64));
        check({tag, " count1"}, 32'(k1), 32'(cnt1));
    endtask

    task automatic run_small(input logic [6:0] v, input string tag);
        int lat, cnt, seen;
        logic m;
        logic [2:0] k;
        model({120'd0, v}, 7, 3, 4, 1'b1, lat, cnt);
        seen = 0; m = 1'b0; k = '0;
        check({tag, " in_ready_s"}, 32'(in_ready_s), 32'd1);
        in_valid_s = 1'b1;
        in_data_s  = v;
        @(posedge clk); #1;
        in_valid_s = 1'b0;
        for (int c = 1; c <= 5; c++) begin
            in_data_s = 7'($urandom());
            @(posedge clk); #1;
            if (out_valid_s && seen == 0) begin seen = c; m = out_maj_s; k = out_count_s; end
        end
        check({tag, " latency_s"}, 32'(seen), 32'(lat));
        check({tag, " maj_s"}, 32'(m), 32'(cnt >= 4));
        check({tag, " count_s"}, 32'(k), 32'(cnt));
    endtask

    initial begin
        int lat0, cnt0, lat1, cnt1;
        logic [126:0] v;
        int any_valid;

        #2 rst_n = 1'b0;
        #1;
        check("reset in_ready0", 32'(in_ready0), 32'd0);
        check("reset out_valid0", 32'(out_valid0), 32'd0);
        check("reset out_maj0", 32'(out_maj0), 32'd0);
        check("reset out_count0", 32'(out_count0), 32'd0);
        check("reset busy0", 32'(busy0), 32'd0);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        @(posedge clk); #1;
        check("post-reset in_ready0", 32'(in_ready0), 32'd1);

        run_main('0, "zeros");
        run_main(low_ones(64), "ones64");
        run_main(low_ones(63), "ones63");
        run_main(low_ones(127), "ones127");
        for (int w = 0; w <= 127; w++) run_main(weight_vec(w), $sformatf("w%0d", w));

        // Backpressure in DONE with a competing vector offered.
        v = weight_vec(70);
        model(v, 127, 16, 64, 1'b0, lat0, cnt0);
        model(v, 127, 16, 64, 1'b1, lat1, cnt1);
        out_ready = 1'b0;
        in_valid = 1'b1;
        in_data  = v;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (8) @(posedge clk);
        #1;
        check("bp out_valid0 rise", 32'(out_valid0), 32'd1);
        for (int c = 0; c < 5; c++) begin
            in_valid = 1'b1;
            in_data  = rand_vec();
            @(posedge clk); #1;
            check("bp out_valid0 hold", 32'(out_valid0), 32'd1);
            check("bp out_maj0 hold", 32'(out_maj0), 32'(cnt0 >= 64));
            check("bp out_count0 hold", 32'(out_count0), 32'(cnt0));
            check("bp in_ready0", 32'(in_ready0), 32'd0);
            check("bp out_count1 hold", 32'(out_count1), 32'(cnt1));
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(posedge clk); #1;
        check("bp out_valid0 drop", 32'(out_valid0), 32'd0);
        check("bp out_valid1 drop", 32'(out_valid1), 32'd0);
        check("bp in_ready0 back", 32'(in_ready0), 32'd1);
        check("bp busy0 idle", 32'(busy0), 32'd0);
        run_main(weight_vec(90), "after bp");

        // Asynchronous reset in the 4th ACCUM cycle.
        in_valid = 1'b1;
        in_data  = low_ones(127);
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b0;
        #1;
        check("abort busy0", 32'(busy0), 32'd0);
        check("abort busy1", 32'(busy1), 32'd0);
        check("abort in_ready0", 32'(in_ready0), 32'd0);
        check("abort out_valid0", 32'(out_valid0), 32'd0);
        check("abort out_count0", 32'(out_count0), 32'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        any_valid = 0;
        for (int c = 0; c < 10; c++) begin
            @(posedge clk); #1;
            if (out_valid0 || out_valid1) any_valid = 1;
        end
        check("abort no out_valid", 32'(any_valid), 32'd0);
        run_main(weight_vec(33), "after abort");

        run_small(7'b0001111, "small 0001111");
        for (int i = 0; i < 16; i++) run_small(7'($urandom()), $sformatf("small r%0d", i));

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/maj_fold_ctrl.md
Name: maj_fold_ctrl

Overview:
Sequential, folded evaluator for wide majority and threshold functions. It accepts an N-bit vector through a valid/ready handshake and streams it, CHUNK bits per cycle, through one shared popcount slice. The running count is compared against THRESH, and the result is returned on a second valid/ready handshake. It is the area-reduced, multi-cycle counterpart to the flat combinational majority trees. It sits between a vector source (stimulus engine or upstream logic) and a result consumer.

Parameters:
- N, 127, input vector width; 1 <= N.
- CHUNK, 16, bits counted per cycle by the shared popcount slice; 1 <= CHUNK <= N.
- THRESH, (N+1)/2, out_maj is 1 when the count is >= THRESH; 1 <= THRESH <= N.
- EARLY_EXIT, 0, when 1 the block stops as soon as the result is decided.
- Derived (not overridable):
  - NCHUNK = ceil(N/CHUNK).
  - CW = clog2(N+1).

Ports:
- clk  in  1  single clock; all state updates on the rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- in_valid  in  1  in_data is valid.
- in_ready  out  1  block can accept a vector.
- in_data  in  N  vector to evaluate.
- out_valid  out  1  result is valid.
- out_ready  in  1  consumer accepts the result.
- out_maj  out  1  1 when popcount >= THRESH.
- out_count  out  CW  ones counted (full popcount, or partial under early exit).
- busy  out  1  high in ACCUM or DONE.

Behaviour:
- Reset (rst_n=0, asynchronous): state=IDLE; in_ready=0 while rst_n is low; out_valid=0, out_maj=0, out_count=0, busy=0; captured vector, chunk index and accumulator cleared. Any in-flight transaction is dropped with no output.
- First cycle after reset release: IDLE, in_ready=1.
- FSM has three states: IDLE, ACCUM, DONE.
- IDLE:
  - in_ready=1.
  - On in_valid&&in_ready at edge E0: capture in_data into an internal register, zero-padded to NCHUNK*CHUNK bits. Clear the accumulator, set idx=0, go to ACCUM.
  - in_data is not sampled after E0.
- ACCUM:
  - in_ready=0.
  - Each edge: acc += popcount(captured chunk idx), then idx++.
  - Padding bits contribute 0.
  - Accumulator width is CW and cannot overflow because acc <= N.
  - Last chunk (idx==NCHUNK-1): go to DONE with out_count=final acc and out_maj=(acc>=THRESH).
  - out_valid rises exactly NCHUNK cycles after E0 (8 for the defaults).
- Early exit (EARLY_EXIT=1 only):
  - After each chunk update, compute rem = number of real (non-pad) bits not yet counted.
  - If acc_new >= THRESH, go to DONE with out_maj=1.
  - Else if acc_new + rem < THRESH, go to DONE with out_maj=0.
  - out_count is then the partial count at that moment.
  - The last-chunk rule still applies if neither condition fires first.
- DONE:
  - out_valid=1.
  - out_maj and out_count are held stable until out_valid&&out_ready.
  - in_ready=0; in_valid is ignored.
  - On handshake: out_valid drops on the next edge, state returns to IDLE, and in_ready=1 from that cycle.
  - Back-to-back rate: one result per NCHUNK+2 cycles, because accept and output never overlap.
  - out_ready may be held high permanently; the handshake then completes in the first DONE cycle.
- busy = (state != IDLE).
- Outputs are registered; nothing on the output side is combinational from in_*.
- Simultaneous events:
  - in_valid while not in IDLE is ignored and not queued.
  - Reset during DONE drops the pending result.

Test Plan:
- Defaults; in_data=0; out_ready=1 -> out_valid exactly 8 cycles after accept; out_maj=0, out_count=0; in_ready back to 1 one cycle after the handshake.
- in_data with bits [63:0]=1, rest 0 -> out_maj=1, out_count=64. Then bits [62:0]=1 -> out_maj=0, out_count=63. Then all 127 ones -> out_maj=1, out_count=127. Also one random vector per hamming weight 0..127, checked against a reference popcount.
- Backpressure: hold out_ready=0 for 5 cycles in DONE, pulse in_valid with a new vector during that time -> out_valid, out_maj and out_count stable; in_ready=0; new vector not captured. After out_ready=1, IDLE and the next vector is accepted normally.
- Change in_data every cycle during ACCUM -> result matches the vector captured at E0.
- Drive rst_n=0 for 1 cycle at the 4th ACCUM cycle -> all outputs 0 immediately (asynchronous), no out_valid for the aborted vector; the next vector after release gives the correct result.
- EARLY_EXIT=1, defaults: all ones -> out_valid 4 cycles after accept, out_maj=1, out_count=64. All zeros -> out_valid after 4 cycles (rem=63<64), out_maj=0, out_count=0. N=7, CHUNK=3, THRESH=4, in_data=7'b0001111 -> out_maj=1, out_count=4, decided after 2 chunks (acc=4).
